// File: rtl/dotacc_pe_acc.sv
// DOTACC processing element: pairs IOB read data into signed lane products,
// reduces across lanes, accumulates per output piece and queues each result.

module dotacc_pe_lane #(
    parameter int DW = 8
) (
    input  logic            i_clk,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] prod
);
    always_ff @(posedge i_clk) begin
        prod <= (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    end
endmodule

module dotacc_pe_acc #(
    parameter int LANES      = 16,
    parameter int DW         = 8,
    parameter int ACCW       = 32,
    parameter int RD_LAT     = 1,
    parameter int LAST_LAT   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_square_mode,
    input  logic                  i_src_from2buffer,
    input  logic                  i_ren0,
    input  logic                  i_ren1,
    input  logic [LANES*DW-1:0]   i_rdata0,
    input  logic [LANES*DW-1:0]   i_rdata1,
    input  logic                  i_dotacc_out,
    output logic                  o_valid,
    output logic [ACCW-1:0]       o_result,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_err,
    output logic                  o_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [RD_LAT-1:0] RD_KEEP_NEW = RD_LAT'(1);
    localparam logic [RD_LAT-1:0] RD_KEEP_ALL = '1;

    // Read-latency alignment; on i_start only the newest enable survives.
    logic [RD_LAT-1:0] renPipe, ren1Pipe;
    logic [RD_LAT:0]   renTap, ren1Tap;
    logic [LAST_LAT:0] lastTap;
    logic              lastInFlight;

    always_comb begin
        renTap  = {renPipe, i_ren0 | i_ren1};
        ren1Tap = {ren1Pipe, i_ren1};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            renPipe  <= '0;
            ren1Pipe <= '0;
        end else begin
            renPipe  <= renTap[RD_LAT-1:0] & (i_start ? RD_KEEP_NEW : RD_KEEP_ALL);
            ren1Pipe <= ren1Tap[RD_LAT-1:0];
        end
    end

    if (LAST_LAT > 0) begin : g_lastDly
        localparam logic [LAST_LAT-1:0] LAST_KEEP_NEW = LAST_LAT'(1);
        localparam logic [LAST_LAT-1:0] LAST_KEEP_ALL = '1;
        logic [LAST_LAT-1:0] lastPipe;
        always_ff @(posedge i_clk) begin
            if (i_rst) lastPipe <= '0;
            else       lastPipe <= lastTap[LAST_LAT-1:0] & (i_start ? LAST_KEEP_NEW : LAST_KEEP_ALL);
        end
        assign lastTap      = {lastPipe, i_dotacc_out};
        assign lastInFlight = |lastPipe;
    end else begin : g_lastNoDly
        assign lastTap      = i_dotacc_out;
        assign lastInFlight = 1'b0;
    end

    logic                       beatVld, beatLast;
    logic [LANES-1:0][DW-1:0]   selWord, opA, opB, bReg, aS1, bS1;
    logic                       phase, phaseNext, latchB, errSet, pairVld;

    assign beatVld  = renTap[RD_LAT];
    assign beatLast = lastTap[LAST_LAT];
    assign selWord  = ren1Tap[RD_LAT] ? i_rdata1 : i_rdata0;

    // Operand selection; normal mode latches b on phase 0 and pairs on phase 1.
    always_comb begin
        opA       = selWord;
        opB       = selWord;
        pairVld   = beatVld;
        phaseNext = phase;
        latchB    = 1'b0;
        errSet    = 1'b0;
        if (i_src_from2buffer) begin
            opA = i_rdata0;
            opB = i_rdata1;
        end else if (!i_square_mode) begin
            opB = bReg;
            if (beatVld) begin
                if (!phase) begin
                    pairVld   = 1'b0;
                    latchB    = 1'b1;
                    phaseNext = 1'b1;
                    errSet    = beatLast;
                end else begin
                    phaseNext = 1'b0;
                end
            end
        end
        if (beatLast) phaseNext = 1'b0;
    end

    logic [2:1] vldPipe, lastStg;
    logic       errR;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_start) begin
            phase   <= 1'b0;
            bReg    <= '0;
            vldPipe <= '0;
            lastStg <= '0;
            errR    <= 1'b0;
        end else begin
            phase   <= phaseNext;
            if (latchB) bReg <= selWord;
            vldPipe <= {vldPipe[1], pairVld};
            lastStg <= {lastStg[1], beatLast};
            if (errSet) errR <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        aS1 <= opA;
        bS1 <= opB;
    end

    logic [LANES-1:0][2*DW-1:0] prodS2;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dotacc_pe_lane #(.DW(DW)) u_lane (
            .i_clk (i_clk),
            .a     (aS1[g]),
            .b     (bS1[g]),
            .prod  (prodS2[g])
        );
    end

    logic [ACCW-1:0] laneSum, acc, accSum;
    logic            accDirty, push;

    always_comb begin
        laneSum = '0;
        for (int i = 0; i < LANES; i++) laneSum = laneSum + ACCW'($signed(prodS2[i]));
    end

    assign accSum = acc + (vldPipe[2] ? laneSum : '0);
    assign push   = lastStg[2] && !i_start;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_start || push) begin
            acc      <= '0;
            accDirty <= 1'b0;
        end else if (vldPipe[2]) begin
            acc      <= accSum;
            accDirty <= 1'b1;
        end
    end

    // Result FIFO; a push into a full FIFO survives only if the head pops.
    logic [ACCW-1:0] fifoMem [FIFO_DEPTH];
    logic [AW:0]     wrPtr, rdPtr, count;
    logic            full, pop, ovfR;

    assign count = wrPtr - rdPtr;
    assign full  = count == (AW+1)'(FIFO_DEPTH);
    assign pop   = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            ovfR  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
        end else begin
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (push && (!full || pop)) begin
                fifoMem[wrPtr[AW-1:0]] <= accSum;
                wrPtr <= wrPtr + 1'b1;
            end
            if (i_start)                    ovfR <= 1'b0;
            else if (push && full && !pop)  ovfR <= 1'b1;
        end
    end

    assign o_valid  = wrPtr != rdPtr;
    assign o_result = fifoMem[rdPtr[AW-1:0]];
    assign o_err    = errR;
    assign o_ovf    = ovfR;
    assign o_busy   = (|renPipe) | lastInFlight | (|vldPipe) | (|lastStg) | phase | accDirty;

endmodule

// File: doc/dotacc_pe_acc.md
Name: dotacc_pe_acc

Overview:
- Datapath stage directly downstream of the DOTACC address generator.
- Consumes the read-enables and out-pulse from the generator, plus the IOB read data that answers those reads.
- Forms per-lane signed products, reduces them across lanes, and accumulates over beats.
- On each out-pulse, pushes one scalar dot-product into a small output FIFO with a valid/ready interface toward writeback.

Parameters:
- LANES, 16, number of parallel data lanes per IOB word.
- DW, 8, signed element width per lane.
- ACCW, 32, accumulator and result width.
- RD_LAT, 1, IOB read latency in cycles, from read-enable to read data.
- LAST_LAT, 0, delay applied to i_dotacc_out so that it coincides with the final data beat.
- FIFO_DEPTH, 4, result FIFO entries (power of two).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_start  in  1  single-cycle job start, same cycle as the AGU start.
- i_square_mode  in  1  square mode, held for the whole job.
- i_src_from2buffer  in  1  two-buffer mode, held for the whole job.
- i_ren0  in  1  IOB port-0 read enable from the AGU.
- i_ren1  in  1  IOB port-1 read enable from the AGU.
- i_rdata0  in  LANES*DW  IOB port-0 read data.
- i_rdata1  in  LANES*DW  IOB port-1 read data.
- i_dotacc_out  in  1  AGU out-pulse; marks the last beat of an output piece.
- o_valid  out  1  result available.
- o_result  out  ACCW  result at the FIFO head.
- i_ready  in  1  consumer accepts the head entry when o_valid is also high.
- o_busy  out  1  a beat is in the pipeline or the accumulator is non-zero-pending.
- o_err  out  1  sticky; out-pulse arrived on an unpaired beat.
- o_ovf  out  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: all outputs are 0, FIFO is empty, accumulator is 0, phase is 0, all pipeline valids are 0.
- Beat valid: (i_ren0|i_ren1) delayed RD_LAT cycles. Beat-last: i_dotacc_out delayed LAST_LAT cycles.
- Lane i occupies bits [i*DW +: DW] of each data word. All elements are signed.
- Operand selection, two-buffer mode (i_src_from2buffer=1): a=i_rdata0, b=i_rdata1. Two-buffer takes priority if both mode inputs are high.
- Operand selection, square mode: a=b=selected word. The selected word is i_rdata1 if the delayed i_ren1 is set, else i_rdata0.
- Operand selection, normal mode: a 1-bit phase toggles on every valid beat.
  - Phase-0 beat: latch the selected word as b; no product is formed.
  - Phase-1 beat: a = selected word, paired with the latched b; a product is formed.
- Pipeline:
  - S1 registers the operands, pair-valid and last.
  - S2 registers the LANES signed products (2*DW bits each).
  - S3 sums the products across lanes, sign-extends the sum to ACCW, and adds it to the accumulator.
- Accumulator arithmetic wraps modulo 2^ACCW; there is no saturation.
- Last handling: when a last beat reaches S3, push acc+sum to the FIFO, then clear acc to 0 and reset phase to 0.
  - A back-to-back first beat of the next piece in the following cycle starts from acc=0.
- Latency: final data beat at cycle T gives o_valid=1 at T+3 when the FIFO is empty.
- Last on a normal-mode phase-0 beat:
  - no product is added for that beat;
  - the current acc is still pushed;
  - o_err is set.
- i_start:
  - clears acc, phase, the latched b, pipeline valids, o_err and o_ovf;
  - does not flush the FIFO;
  - a beat already in flight when i_start arrives is discarded.
- FIFO:
  - pop when o_valid&i_ready;
  - push when full with no pop drops the new result and sets o_ovf;
  - push and pop in the same cycle while full is accepted with no loss;
  - o_result is held stable while o_valid=1 and i_ready=0.
- o_busy = any pipeline valid, OR phase=1, OR acc has been updated since the last push.
- Reset mid-job: everything returns to reset values on the next clock edge, including FIFO contents.

Test Plan:
- Two-buffer mode, 3 beats, all lanes a=2 and b=3, last on beat 3 -> one result of 288 (3*16*6), o_valid 3 cycles after the last data beat.
- Normal mode, beats b=1 then a=-4 in all lanes, last on the second beat -> result -64; phase returns to 0; o_err=0.
- Square mode, i_ren1 only, lanes = -128 -> single-beat result 262144 (16*16384); verifies sign handling and port selection.
- Normal mode with last on a phase-0 beat -> o_err=1, result equals the prior accumulation; next i_start clears o_err.
- Hold i_ready=0 and issue 5 pieces -> 4 results retained, o_ovf=1; drain -> the 4 results come out in order, unchanged.
- Last pulses on consecutive cycles in two-buffer mode -> two independent results; the second excludes the first piece's sum.
